// File: rtl/oflow_pe_feeder.sv
// Streams a frame's previous-frame feature rows to the PE two at a time:
// fetch a row pair from the buffer, present it, then wait for the PE's next-pair request.
module oflow_pe_feeder #(
  parameter int DATA_TO_PE_WIDTH = 128,
  parameter int ROW_LEN          = 5,
  parameter int ADDR_LEN         = 6
) (
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic                        start_read,
  input  logic [ADDR_LEN-1:0]         num_of_rows,
  input  logic                        control_for_read_new_line,
  output logic                        mem_rd_en,
  output logic [ADDR_LEN-1:0]         mem_addr_0,
  output logic [ADDR_LEN-1:0]         mem_addr_1,
  input  logic [DATA_TO_PE_WIDTH-1:0] mem_rdata_0,
  input  logic [DATA_TO_PE_WIDTH-1:0] mem_rdata_1,
  output logic [DATA_TO_PE_WIDTH-1:0] data_to_pe_0,
  output logic [DATA_TO_PE_WIDTH-1:0] data_to_pe_1,
  output logic                        data_to_pe_1_valid,
  output logic [ROW_LEN-1:0]          row_sel_to_pe,
  output logic                        done_read_to_pe,
  output logic                        busy,
  output logic [2:0]                  dbg_state
);

  // Handshake: start_read is a one-cycle pulse honoured only in S_IDLE;
  // control_for_read_new_line is a one-cycle pulse honoured only in S_WAIT_REQ.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_PRESENT  = 3'd3,
    S_WAIT_REQ = 3'd4
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [ADDR_LEN-1:0]         r_num_rows;
  logic [ROW_LEN-1:0]          r_pair;
  logic                        r_zero_done;
  logic [DATA_TO_PE_WIDTH-1:0] r_data_0;
  logic [DATA_TO_PE_WIDTH-1:0] r_data_1;
  logic                        r_data_1_valid;
  logic [ROW_LEN-1:0]          r_row_sel;

  logic                        w_start;
  logic                        w_start_zero;
  logic                        w_next_req;
  logic [ADDR_LEN:0]           w_num_pairs;
  logic [ADDR_LEN:0]           w_pair_ext;
  logic [ADDR_LEN:0]           w_odd_row;
  logic                        w_last_pair;
  logic                        w_odd_tail;
  logic [ADDR_LEN-1:0]         w_addr_even;

  assign w_start      = (r_state == S_IDLE) && start_read;
  assign w_start_zero = w_start && (num_of_rows == '0);
  assign w_next_req   = (r_state == S_WAIT_REQ) && control_for_read_new_line;

  // One extra bit so ceil(rows/2) and 2*pair+1 never overflow at the top of the range.
  assign w_num_pairs  = ({1'b0, r_num_rows} + (ADDR_LEN+1)'(1)) >> 1;
  assign w_pair_ext   = (ADDR_LEN+1)'(r_pair);
  assign w_last_pair  = (w_pair_ext + (ADDR_LEN+1)'(1)) == w_num_pairs;
  assign w_odd_row    = (ADDR_LEN+1)'({r_pair, 1'b1});
  assign w_odd_tail   = w_odd_row >= {1'b0, r_num_rows};
  assign w_addr_even  = ADDR_LEN'({r_pair, 1'b0});

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (start_read && (num_of_rows != '0)) w_next_state = S_FETCH;
      S_FETCH:    w_next_state = S_WAIT_MEM;
      S_WAIT_MEM: w_next_state = S_PRESENT;
      S_PRESENT:  w_next_state = w_last_pair ? S_IDLE : S_WAIT_REQ;
      S_WAIT_REQ: if (control_for_read_new_line) w_next_state = S_FETCH;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en       = (r_state == S_FETCH);
    mem_addr_0      = '0;
    mem_addr_1      = '0;
    if (r_state == S_FETCH) begin
      mem_addr_0 = w_addr_even;
      mem_addr_1 = w_addr_even | ADDR_LEN'(1);
    end
    // Empty frame finishes straight from IDLE with a registered pulse.
    done_read_to_pe = ((r_state == S_PRESENT) && w_last_pair) || r_zero_done;
    busy            = (r_state != S_IDLE);
    dbg_state       = r_state;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_num_rows  <= '0;
      r_pair      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_start_zero;
      if (w_start) begin
        r_num_rows <= num_of_rows;
        r_pair     <= '0;
      end else if (w_next_req) begin
        r_pair     <= r_pair + ROW_LEN'(1);
      end
    end
  end

  // Presented pair is held until the next WAIT_MEM load.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_data_0       <= '0;
      r_data_1       <= '0;
      r_data_1_valid <= 1'b0;
      r_row_sel      <= '0;
    end else if (r_state == S_WAIT_MEM) begin
      r_data_0       <= mem_rdata_0;
      r_data_1       <= w_odd_tail ? '0 : mem_rdata_1;
      r_data_1_valid <= !w_odd_tail;
      r_row_sel      <= r_pair;
    end
  end

  assign data_to_pe_0       = r_data_0;
  assign data_to_pe_1       = r_data_1;
  assign data_to_pe_1_valid = r_data_1_valid;
  assign row_sel_to_pe      = r_row_sel;

endmodule

// File: doc/oflow_pe_feeder.md
OFLOW_PE_FEEDER -- requirements
Module: oflow_pe_feeder

Interface
REQ-001 SHALL have parameter DATA_TO_PE_WIDTH, default 128, width of one previous-frame feature row.
REQ-002 SHALL have parameter ROW_LEN, default 5, width of the pair/row index (max 2^ROW_LEN pairs).
REQ-003 SHALL have parameter ADDR_LEN, default 6, width of the buffer memory address.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_N  input  1  asynchronous, active-low reset.
REQ-006 start_read  input  1  one-cycle pulse from core_fsm; begins streaming one frame's previous rows.
REQ-007 num_of_rows  input  ADDR_LEN  count of valid previous-frame rows; sampled on start_read.
REQ-008 control_for_read_new_line  input  1  pulse from PE requesting the next row pair.
REQ-009 mem_rd_en  output  1  buffer memory read strobe.
REQ-010 mem_addr_0, mem_addr_1  output  ADDR_LEN each  read addresses for the even and odd row.
REQ-011 mem_rdata_0, mem_rdata_1  input  DATA_TO_PE_WIDTH each  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 data_to_pe_0, data_to_pe_1  output  DATA_TO_PE_WIDTH each  row pair presented to the PE.
REQ-013 data_to_pe_1_valid  output  1  high when data_to_pe_1 holds a real row (low for the odd tail).
REQ-014 row_sel_to_pe  output  ROW_LEN  index of the pair currently presented.
REQ-015 done_read_to_pe  output  1  one-cycle pulse marking the last pair.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, WAIT_MEM, PRESENT, WAIT_REQ.
REQ-018 IDLE: on start_read, latch num_of_rows, clear the pair counter, go to FETCH; if num_of_rows==0, stay in IDLE and pulse done_read_to_pe the next cycle with no memory read.
REQ-019 FETCH: assert mem_rd_en for one cycle, mem_addr_0=2*pair, mem_addr_1=2*pair+1; go to WAIT_MEM.
REQ-020 WAIT_MEM: register mem_rdata_0/1 into data_to_pe_0/1, set row_sel_to_pe=pair; go to PRESENT.
REQ-021 Outputs SHALL become valid in the cycle after WAIT_MEM, i.e. 3 cycles after start_read for pair 0.
REQ-022 Odd tail: if 2*pair+1 >= num_of_rows, data_to_pe_1 SHALL be loaded with zero and data_to_pe_1_valid SHALL be 0; otherwise it SHALL be 1.
REQ-023 PRESENT: if this is the last pair, pulse done_read_to_pe for exactly this cycle and go to IDLE; else go to WAIT_REQ.
REQ-024 WAIT_REQ: on control_for_read_new_line, increment pair and go to FETCH; otherwise hold.
REQ-025 control_for_read_new_line SHALL be ignored in IDLE, FETCH, WAIT_MEM, PRESENT.
REQ-026 start_read SHALL be ignored unless the state is IDLE.
REQ-027 data_to_pe_*, data_to_pe_1_valid, row_sel_to_pe SHALL hold their values until the next WAIT_MEM load or reset.
REQ-028 Last pair SHALL be pair == ceil(num_of_rows/2)-1; the pair counter SHALL never wrap.
REQ-029 mem_rd_en SHALL be high only in FETCH; mem_addr_* SHALL be 0 whenever mem_rd_en is low.

Reset
REQ-030 On reset_N low, all outputs SHALL go to 0 and the state to IDLE immediately, including mid-stream; no done_read_to_pe SHALL follow.
REQ-031 After reset release the block SHALL accept start_read on the first rising edge.

Verification
REQ-032 num_of_rows=4, rows A,B,C,D, request pulse per PRESENT -> pair0 (A,B,valid1,row_sel 0) at cycle 3, pair1 (C,D,row_sel 1) with done_read_to_pe pulse; 2 mem_rd_en total.
REQ-033 num_of_rows=3 -> pair1 = (C, 0), data_to_pe_1_valid=0, done_read_to_pe pulses once.
REQ-034 num_of_rows=0 -> no mem_rd_en, single done_read_to_pe pulse 1 cycle after start_read, busy stays 0.
REQ-035 PE delays request 10 cycles in WAIT_REQ -> outputs stable, no mem_rd_en until request arrives.
REQ-036 reset_N low during WAIT_REQ of pair 1 of 6 rows -> all outputs 0 asynchronously; new start_read restarts at pair 0, address 0.
REQ-037 start_read and stray control_for_read_new_line asserted while busy -> ignored; row sequence and pulse count unchanged.
